array_seq_ctrl: RTL
===================

Name: array_seq_ctrl

Overview:
- Sequencer for the SIZE x SIZE systolic MAC array; computes C = A x B for an inner dimension of k_len.
- Fetches operand columns of A and rows of B from two operand SRAMs, skews them onto the array row/column boundaries, and drives mult_en, acc_en and load_en.
- Streams the SIZE*SIZE results out through the array's select/d_out readout using a valid/ready handshake.
- Sits between the matrix-processor top-level command logic and the array.

Parameters:
SIZE, 4, array dimension; same value as the controlled array.
K_MAX, 16, maximum inner dimension; sets op_addr width AW = $clog2(K_MAX).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  command pulse; sampled only in IDLE
k_len  input  $clog2(K_MAX+1)  inner dimension, latched on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last result is accepted
op_rd_en  output  1  operand SRAM read strobe (A and B SRAMs share it)
op_addr  output  AW  operand index k
a_rdata  input  SIZE*8  A column k, lane i = row i; valid 1 cycle after op_rd_en
b_rdata  input  SIZE*8  B row k, lane j = column j; valid 1 cycle after op_rd_en
arr_a  output  SIZE*8  to array a_in
arr_b  output  SIZE*8  to array b_in
mult_en  output  1  to array
acc_en  output  1  to array
load_en  output  1  to array; one-cycle accumulator clear
select  output  $clog2(SIZE*SIZE)  to array
d_out  input  32  from array
out_valid  output  1  result valid
out_ready  input  1  result accepted when out_valid && out_ready
out_data  output  32  equals d_out (combinational pass-through)
out_idx  output  $clog2(SIZE*SIZE)  result index i*SIZE+j; equals select

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0; skew registers 0; state IDLE.
- Reset asserted at any time, including mid-operation, aborts the operation. No done pulse is issued.
- FSM states:
  - IDLE: start -> latch k_len, go to CLEAR. A k_len of 0 is treated as 1.
  - CLEAR: 1 cycle. load_en=1. Go to FEED.
  - FEED: k_len cycles. op_rd_en=1; op_addr counts 0..k_len-1. Go to FLUSH.
  - FLUSH: 2*SIZE-1 cycles. Covers read latency plus skew/propagation. Go to DRAIN.
  - DRAIN: out_valid=1; select = out_idx = counter starting at 0.
    - Counter increments on each handshake.
    - Handshake at SIZE*SIZE-1 -> done=1 for that next cycle, go to IDLE.
    - out_valid stays high while out_ready is low; select is held.
- busy=1 in every state except IDLE. start while busy is ignored.
- mult_en = acc_en = 1 from the cycle after the first op_rd_en through the last FLUSH cycle, i.e. k_len+2*SIZE-2 cycles. They are 0 otherwise, including throughout DRAIN.
- Skew datapath:
  - arr_a lane i = a_rdata lane i delayed by i registers.
  - arr_b lane j = b_rdata lane j delayed by j registers.
  - Lane 0 has zero added delay.
  - A valid bit travels with each lane; the lane drives 8'h00 whenever its delayed valid is 0, so only zeros enter outside the data window.
- Element (i,j) sees operand k at cycle t0+k+i+j, where t0 is the first data cycle. The final product lands inside the enable window.
- No arithmetic in this block; result width and wrap are defined by the array.
- busy duration per command: 1 + k_len + (2*SIZE-1) + drain cycles. Drain takes SIZE*SIZE cycles with out_ready held high.

Test Plan:
- SIZE=4, k_len=4, A=identity, B[k][j]=k*4+j+1 -> out_idx 0..15 returns 1..16 in order; done pulse once; busy exactly 1+4+7+16=28 cycles.
- SIZE=4, k_len=1, a col=(1,2,3,4), b row=(5,6,7,8) -> out_data at idx i*4+j = (i+1)*(j+5); mult_en high for exactly 7 cycles.
- Drain backpressure: out_ready low for 3 cycles at idx 5 -> out_valid stays 1, select stays 5, no idx skipped, 16 transfers total.
- start pulsed during FEED and during DRAIN -> ignored; op_addr sequence is unchanged; exactly one done.
- reset asserted for 1 cycle mid-FEED -> next cycle all outputs 0 and state IDLE; a fresh start then produces correct results (load_en clears stale sums).
- Back-to-back: start asserted the cycle after done -> second command accepted; its results are independent of the first.

Source files
------------

// File: rtl/array_seq_ctrl_if.sv
// array_seq_ctrl_if
//   Bundles every signal between the systolic-array sequencer and its
//   surroundings (command logic, operand SRAMs, MAC array, result sink).
//   clk/reset are plain ports on the controller and are not carried here.
//
//   Command : start, k_len -> ; <- busy, done
//   Operand : <- op_rd_en, op_addr ; a_rdata, b_rdata ->
//   Array   : <- arr_a, arr_b, mult_en, acc_en, load_en, select ; d_out ->
//   Result  : <- out_valid, out_data, out_idx ; out_ready ->
//
//   modport master : the sequencer
//   modport slave  : the environment driving/consuming the sequencer
interface array_seq_ctrl_if #(
    parameter int SIZE  = 4,
    parameter int K_MAX = 16
);
    localparam int AW = $clog2(K_MAX);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int SW = $clog2(SIZE * SIZE);

    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy;
    logic              done;
    logic              op_rd_en;
    logic [AW-1:0]     op_addr;
    logic [SIZE*8-1:0] a_rdata;
    logic [SIZE*8-1:0] b_rdata;
    logic [SIZE*8-1:0] arr_a;
    logic [SIZE*8-1:0] arr_b;
    logic              mult_en;
    logic              acc_en;
    logic              load_en;
    logic [SW-1:0]     select;
    logic [31:0]       d_out;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [SW-1:0]     out_idx;

    modport master (
        input  start, k_len, a_rdata, b_rdata, d_out, out_ready,
        output busy, done, op_rd_en, op_addr, arr_a, arr_b,
               mult_en, acc_en, load_en, select,
               out_valid, out_data, out_idx
    );

    modport slave (
        output start, k_len, a_rdata, b_rdata, d_out, out_ready,
        input  busy, done, op_rd_en, op_addr, arr_a, arr_b,
               mult_en, acc_en, load_en, select,
               out_valid, out_data, out_idx
    );
endinterface

// File: rtl/array_seq_ctrl.sv
// array_seq_ctrl
//   Sequencer for a SIZE x SIZE systolic MAC array computing C = A x B with
//   inner dimension k_len. Clears the accumulators, streams A columns and
//   B rows from the operand SRAMs through a per-lane skew onto the array
//   boundaries, waits for the wavefront to finish, then reads the SIZE*SIZE
//   results out over a valid/ready handshake.
//
//   Ports:
//     clk   : clock
//     reset : synchronous active-high reset; aborts any operation
//     bus   : array_seq_ctrl_if.master (command, operand SRAM, array and
//             result signals)
module array_seq_ctrl #(
    parameter int SIZE  = 4,
    parameter int K_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    array_seq_ctrl_if.master  bus
);
    localparam int AW = $clog2(K_MAX);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int SW = $clog2(SIZE * SIZE);
    localparam int CW = (KW > SW) ? KW : SW;

    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * SIZE - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(SIZE * SIZE - 1);
    localparam logic [KW-1:0] KMAX_V     = KW'(K_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] klen_q, klen_d;
    logic          done_q, done_d;
    logic          rd_vld_q;

    logic [SIZE*8-1:0] arr_a_w;
    logic [SIZE*8-1:0] arr_b_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            klen_q   <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            klen_q   <= klen_d;
            done_q   <= done_d;
            rd_vld_q <= bus.op_rd_en;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        klen_d        = klen_q;
        done_d        = 1'b0;
        bus.load_en   = 1'b0;
        bus.op_rd_en  = 1'b0;
        bus.op_addr   = '0;
        bus.mult_en   = 1'b0;
        bus.acc_en    = 1'b0;
        bus.out_valid = 1'b0;
        bus.select    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Zero-length requests run as one step; oversize ones
                    // saturate so op_addr never wraps.
                    if (bus.k_len == '0)
                        klen_d = KW'(1);
                    else if (bus.k_len > KMAX_V)
                        klen_d = KMAX_V;
                    else
                        klen_d = bus.k_len;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.load_en = 1'b1;
                cnt_d       = '0;
                state_d     = S_FEED;
            end
            S_FEED: begin
                bus.op_rd_en = 1'b1;
                bus.op_addr  = cnt_q[AW-1:0];
                // Read data lags the strobe by one cycle, so the enable
                // window opens on the second FEED cycle.
                bus.mult_en  = (cnt_q != '0);
                bus.acc_en   = (cnt_q != '0);
                if (cnt_q == CW'(klen_q) - CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                bus.mult_en = 1'b1;
                bus.acc_en  = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                bus.out_valid = 1'b1;
                bus.select    = cnt_q[SW-1:0];
                if (bus.out_ready) begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.out_idx  = bus.select;
    assign bus.out_data = bus.d_out;
    assign bus.arr_a    = arr_a_w;
    assign bus.arr_b    = arr_b_w;

    // Lane n is delayed n cycles behind the SRAM read data. Each lane carries
    // its own valid bit so anything outside the data window enters as zero.
    for (genvar n = 0; n < SIZE; n++) begin : g_lane
        if (n == 0) begin : g_direct
            assign arr_a_w[7:0] = rd_vld_q ? bus.a_rdata[7:0] : 8'h00;
            assign arr_b_w[7:0] = rd_vld_q ? bus.b_rdata[7:0] : 8'h00;
        end else begin : g_skew
            logic [7:0] ad_q [n];
            logic [7:0] bd_q [n];
            logic       v_q  [n];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned s = 0; s < n; s++) begin
                        ad_q[s] <= '0;
                        bd_q[s] <= '0;
                        v_q[s]  <= 1'b0;
                    end
                end else begin
                    ad_q[0] <= bus.a_rdata[n*8 +: 8];
                    bd_q[0] <= bus.b_rdata[n*8 +: 8];
                    v_q[0]  <= rd_vld_q;
                    for (int unsigned s = 1; s < n; s++) begin
                        ad_q[s] <= ad_q[s-1];
                        bd_q[s] <= bd_q[s-1];
                        v_q[s]  <= v_q[s-1];
                    end
                end
            end

            assign arr_a_w[n*8 +: 8] = v_q[n-1] ? ad_q[n-1] : 8'h00;
            assign arr_b_w[n*8 +: 8] = v_q[n-1] ? bd_q[n-1] : 8'h00;
        end
    end
endmodule
